// File: rtl/edge_detect_multi.sv
// edge_detect_multi: synchronised, glitch-filtered multi-channel edge detector with sticky status and irq
module edge_detect_multi #(
  parameter int NUM_CH        = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     a_i,
  input  logic [2*NUM_CH-1:0]   mode_i,
  input  logic [NUM_CH-1:0]     clr_i,
  output logic [NUM_CH-1:0]     level_o,
  output logic [NUM_CH-1:0]     rise_o,
  output logic [NUM_CH-1:0]     fall_o,
  output logic [NUM_CH-1:0]     edge_o,
  output logic [NUM_CH-1:0]     status_o,
  output logic [NUM_CH-1:0]     ovf_o,
  output logic                  irq_o
);
  localparam int CW = $clog2(FILTER_CYCLES) + 1;
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] s, level_d, status_q, ovf_q, mode_r, mode_f;
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    else begin
      sync_q[0] <= a_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  assign s = sync_q[SYNC_STAGES-1];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic          lvl;
    logic [CW-1:0] c;
    // level only moves after s has differed from it for FILTER_CYCLES consecutive cycles
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        lvl <= 1'b0;
        c   <= '0;
      end else if (s[i] == lvl) c <= '0;
      else if (c == CW'(FILTER_CYCLES - 1)) begin
        lvl <= s[i];
        c   <= '0;
      end else c <= c + 1'b1;
    assign level_o[i] = lvl;
    assign mode_r[i]  = mode_i[2*i];
    assign mode_f[i]  = mode_i[2*i+1];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      level_d  <= '0;
      status_q <= '0;
      ovf_q    <= '0;
    end else begin
      level_d  <= level_o;
      status_q <= edge_o | (status_q & ~clr_i);
      ovf_q    <= (ovf_q | (edge_o & status_q)) & ~clr_i;
    end
  assign rise_o   = level_o & ~level_d;
  assign fall_o   = ~level_o & level_d;
  assign edge_o   = (rise_o & mode_r) | (fall_o & mode_f);
  assign status_o = status_q;
  assign ovf_o    = ovf_q;
  assign irq_o    = |status_q;
endmodule

// File: tb/tb_edge_detect_multi.sv
// tb_edge_detect_multi: directed table and sequence checks for edge_detect_multi (4 ch, 2 sync, filter 3)
module tb_edge_detect_multi;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] a_i, clr_i, level_o, rise_o, fall_o, edge_o, status_o, ovf_o;
  logic [7:0] mode_i;
  logic       irq_o;
  int checks = 0, failures = 0;
  edge_detect_multi #(.NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .a_i(a_i), .mode_i(mode_i), .clr_i(clr_i),
    .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o), .edge_o(edge_o),
    .status_o(status_o), .ovf_o(ovf_o), .irq_o(irq_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] a;
    logic [7:0] mode;
    logic [3:0] clr, lvl, rise, fall, edg, st, ov;
    logic       irq;
  } vec_t;
  vec_t tbl [14];
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all_zero(input string nm);
    chk({nm, ".level"}, {4'h0, level_o}, 8'h0);
    chk({nm, ".rise"}, {4'h0, rise_o}, 8'h0);
    chk({nm, ".fall"}, {4'h0, fall_o}, 8'h0);
    chk({nm, ".edge"}, {4'h0, edge_o}, 8'h0);
    chk({nm, ".status"}, {4'h0, status_o}, 8'h0);
    chk({nm, ".ovf"}, {4'h0, ovf_o}, 8'h0);
    chk({nm, ".irq"}, {7'h0, irq_o}, 8'h0);
  endtask
  initial begin
    int rc, fc, ec, ef;
    logic st_fall, found;
    reset = 1'b1; a_i = '0; mode_i = '0; clr_i = '0;
    for (int i = 0; i < 4; i++) tbl[i] = '{4'h1, 8'h01, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[4] = '{4'h1, 8'h01, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0};
    for (int i = 5; i < 7; i++) tbl[i] = '{4'h1, 8'h01, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1};
    for (int i = 7; i < 9; i++) tbl[i] = '{4'h3, 8'h0D, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1};
    for (int i = 9; i < 14; i++) tbl[i] = '{4'h1, 8'h0D, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1};
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    reset = 1'b0;
    // ch0 rise with mode 01, then a 2-cycle glitch on ch1 that must be filtered out
    for (int i = 0; i < 14; i++) begin
      a_i = tbl[i].a; mode_i = tbl[i].mode; clr_i = tbl[i].clr;
      step();
      chk($sformatf("v%0d.level", i), {4'h0, level_o}, {4'h0, tbl[i].lvl});
      chk($sformatf("v%0d.rise", i), {4'h0, rise_o}, {4'h0, tbl[i].rise});
      chk($sformatf("v%0d.fall", i), {4'h0, fall_o}, {4'h0, tbl[i].fall});
      chk($sformatf("v%0d.edge", i), {4'h0, edge_o}, {4'h0, tbl[i].edg});
      chk($sformatf("v%0d.status", i), {4'h0, status_o}, {4'h0, tbl[i].st});
      chk($sformatf("v%0d.ovf", i), {4'h0, ovf_o}, {4'h0, tbl[i].ov});
      chk($sformatf("v%0d.irq", i), {7'h0, irq_o}, {7'h0, tbl[i].irq});
    end
    // ch2 falling-only mode
    mode_i = 8'h2D; a_i = 4'h5;
    rc = 0; fc = 0; ec = 0; ef = 0; st_fall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      rc += int'(rise_o[2]); fc += int'(fall_o[2]); ec += int'(edge_o[2]);
    end
    chk("ch2.status_after_rise", {7'h0, status_o[2]}, 8'h0);
    a_i = 4'h1;
    for (int i = 0; i < 12; i++) begin
      step();
      rc += int'(rise_o[2]); fc += int'(fall_o[2]); ec += int'(edge_o[2]);
      ef += int'(edge_o[2] & fall_o[2]);
      if (fall_o[2]) st_fall = status_o[2];
    end
    chk("ch2.rise_cnt", 8'(rc), 8'd1);
    chk("ch2.fall_cnt", 8'(fc), 8'd1);
    chk("ch2.edge_cnt", 8'(ec), 8'd1);
    chk("ch2.edge_on_fall", 8'(ef), 8'd1);
    chk("ch2.status_in_fall_cycle", {7'h0, st_fall}, 8'h0);
    chk("ch2.status_end", {4'h0, status_o}, 8'h5);
    clr_i = 4'h5;
    step();
    clr_i = 4'h0;
    chk("clr02.status", {4'h0, status_o}, 8'h0);
    chk("clr02.irq", {7'h0, irq_o}, 8'h0);
    // ch3 two edges without clear -> overflow
    mode_i = 8'hED; a_i = 4'h9;
    repeat (10) step();
    chk("ch3.status_1st", {4'h0, status_o}, 8'h8);
    chk("ch3.ovf_1st", {4'h0, ovf_o}, 8'h0);
    a_i = 4'h1;
    repeat (10) step();
    chk("ch3.status_2nd", {4'h0, status_o}, 8'h8);
    chk("ch3.ovf_2nd", {4'h0, ovf_o}, 8'h8);
    chk("ch3.irq", {7'h0, irq_o}, 8'h1);
    clr_i = 4'h8;
    step();
    clr_i = 4'h0;
    chk("ch3.status_clr", {4'h0, status_o}, 8'h0);
    chk("ch3.ovf_clr", {4'h0, ovf_o}, 8'h0);
    chk("ch3.irq_clr", {7'h0, irq_o}, 8'h0);
    // clear coinciding with a new edge on ch0 while status is already set
    mode_i = 8'hEF; a_i = 4'h0;
    repeat (8) step();
    chk("ch0.status_pre", {7'h0, status_o[0]}, 8'h1);
    chk("ch0.ovf_pre", {7'h0, ovf_o[0]}, 8'h0);
    a_i = 4'h1; found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (edge_o[0]) begin
        found = 1'b1;
        clr_i = 4'h1;
        step();
        clr_i = 4'h0;
      end
    end
    chk("ch0.edge_seen", {7'h0, found}, 8'h1);
    chk("ch0.status_keep", {7'h0, status_o[0]}, 8'h1);
    chk("ch0.ovf_keep", {7'h0, ovf_o[0]}, 8'h0);
    step();
    chk("ch0.status_hold", {7'h0, status_o[0]}, 8'h1);
    // asynchronous reset while ch1 filter is mid-count, inputs stay high
    a_i = 4'h3;
    repeat (4) step();
    chk("rst.level_pre", {4'h0, level_o}, 8'h1);
    #2 reset = 1'b1;
    #1;
    chk_all_zero("rst_async");
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk($sformatf("rel%0d.rise", e), {4'h0, rise_o}, (e == 5) ? 8'h3 : 8'h0);
      chk($sformatf("rel%0d.level", e), {4'h0, level_o}, (e == 5) ? 8'h3 : 8'h0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
